// File: rtl/guard_sequencer_pkg.sv
// Shared definitions for the guard sequencer: opcodes, instruction field layout, FSM states.
package rte_seq_pkg;

    localparam logic [1:0] OP_GUARD = 2'b00;
    localparam logic [1:0] OP_TAKE  = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int OPC_LSB    = 22;
    localparam int OPC_W      = 2;
    localparam int CMP_OP_BIT = 21;
    localparam int LNG_BIT    = 20;
    localparam int ADDR_LSB   = 18;
    localparam int ADDR_W     = 2;
    localparam int IMM_HI_LSB = 10;
    localparam int IMM_HI_W   = 8;
    localparam int IMM_LO_LSB = 6;
    localparam int IMM_LO_W   = 4;
    localparam int MASK_LSB   = 14;
    localparam int MASK_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_END
    } state_e;

endpackage

// File: rtl/guard_sequencer_decode.sv
// Combinational field extraction from a program word; the same bits are read
// differently depending on the opcode, so every view is produced in parallel.
module seq_decode
    import rte_seq_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = 24
) (
    input  logic [IW-1:0]       prog_data,
    output logic [OPC_W-1:0]    opcode,
    output logic                cmp_op,
    output logic                cmp_lng,
    output logic [ADDR_W-1:0]   cmp_addr,
    output logic [IMM_LO_W-1:0] cmp_imm_lo,
    output logic [IMM_HI_W-1:0] cmp_imm_hi,
    output logic [MASK_W-1:0]   reset_mask,
    output logic [AW-1:0]       target
);

    assign opcode     = prog_data[OPC_LSB +: OPC_W];
    assign cmp_op     = prog_data[CMP_OP_BIT];
    assign cmp_lng    = prog_data[LNG_BIT];
    assign cmp_addr   = prog_data[ADDR_LSB +: ADDR_W];
    assign cmp_imm_lo = prog_data[IMM_LO_LSB +: IMM_LO_W];
    assign cmp_imm_hi = prog_data[IMM_HI_LSB +: IMM_HI_W];
    assign reset_mask = prog_data[MASK_LSB +: MASK_W];
    assign target     = prog_data[AW-1:0];

endmodule

// File: rtl/guard_sequencer.sv
// Walks the guard/transition list of the current location, drives the clock
// constraint query ports, and fires at most one transition per evaluation pass.
module guard_sequencer #(
    parameter int AW = 8,
    parameter int IW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          out_val,
    output logic          en,
    output logic          lng,
    output logic          op,
    output logic [1:0]    addr,
    output logic [3:0]    imm_lo,
    output logic [7:0]    imm_hi,
    output logic          en_clk_reset,
    output logic [7:0]    clk_reset,
    output logic [AW-1:0] loc,
    output logic          busy,
    output logic          done,
    output logic          taken,
    output logic          illegal
);
    import rte_seq_pkg::*;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, prog_addr_q, prog_addr_d, loc_q, loc_d;
    logic [AW-1:0] ir_target_q, ir_target_d;
    logic [1:0]    ir_opcode_q, ir_opcode_d;
    logic          acc_q, acc_d;
    logic          op_q, op_d, lng_q, lng_d;
    logic [1:0]    addr_q, addr_d;
    logic [3:0]    imm_lo_q, imm_lo_d;
    logic [7:0]    imm_hi_q, imm_hi_d, clk_reset_q, clk_reset_d;
    logic          en_q, en_d, done_q, done_d, busy_q, busy_d;
    logic          en_clk_reset_q, en_clk_reset_d, taken_q, taken_d, illegal_q, illegal_d;
    logic          advance;

    logic [1:0]    dec_opcode;
    logic          dec_op, dec_lng;
    logic [1:0]    dec_addr;
    logic [3:0]    dec_imm_lo;
    logic [7:0]    dec_imm_hi, dec_mask;
    logic [AW-1:0] dec_target;
    logic [AW-1:0] pc_inc;

    seq_decode #(.AW(AW), .IW(IW)) u_decode (
        .prog_data  (prog_data),
        .opcode     (dec_opcode),
        .cmp_op     (dec_op),
        .cmp_lng    (dec_lng),
        .cmp_addr   (dec_addr),
        .cmp_imm_lo (dec_imm_lo),
        .cmp_imm_hi (dec_imm_hi),
        .reset_mask (dec_mask),
        .target     (dec_target)
    );

    assign pc_inc = pc_q + 1'b1;

    // The clock-reset pulse is decided in DECODE: acc cannot change between
    // DECODE and EXEC, so registering it here lands the pulse on the TAKE's EXEC cycle.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        prog_addr_d    = prog_addr_q;
        loc_d          = loc_q;
        ir_target_d    = ir_target_q;
        ir_opcode_d    = ir_opcode_q;
        acc_d          = acc_q;
        op_d           = op_q;
        lng_d          = lng_q;
        addr_d         = addr_q;
        imm_lo_d       = imm_lo_q;
        imm_hi_d       = imm_hi_q;
        clk_reset_d    = clk_reset_q;
        en_clk_reset_d = 1'b0;
        taken_d        = taken_q;
        illegal_d      = illegal_q;
        advance        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d        = loc_q;
                    prog_addr_d = loc_q;
                    acc_d       = 1'b1;
                    taken_d     = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_opcode_d = dec_opcode;
                ir_target_d = dec_target;
                op_d        = dec_op;
                lng_d       = dec_lng;
                addr_d      = dec_addr;
                imm_lo_d    = dec_imm_lo;
                imm_hi_d    = dec_imm_hi;
                if (dec_opcode == OP_TAKE && acc_q) begin
                    en_clk_reset_d = 1'b1;
                    clk_reset_d    = dec_mask;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir_opcode_q)
                    OP_GUARD: begin
                        acc_d   = acc_q & out_val;
                        advance = 1'b1;
                    end
                    OP_TAKE: begin
                        if (acc_q) begin
                            loc_d   = ir_target_q;
                            taken_d = 1'b1;
                            state_d = S_END;
                        end else begin
                            acc_d   = 1'b1;
                            advance = 1'b1;
                        end
                    end
                    OP_END:  state_d = S_END;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_END;
                    end
                endcase
                // Running off the end of program memory is a program error, not a wrap.
                if (advance) begin
                    if (pc_q == {AW{1'b1}}) begin
                        illegal_d = 1'b1;
                        state_d   = S_END;
                    end else begin
                        pc_d        = pc_inc;
                        prog_addr_d = pc_inc;
                        state_d     = S_FETCH;
                    end
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        en_d   = (state_d == S_END);
        done_d = (state_d == S_END);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            prog_addr_q    <= '0;
            loc_q          <= '0;
            ir_target_q    <= '0;
            ir_opcode_q    <= OP_GUARD;
            acc_q          <= 1'b1;
            op_q           <= 1'b0;
            lng_q          <= 1'b0;
            addr_q         <= '0;
            imm_lo_q       <= '0;
            imm_hi_q       <= '0;
            clk_reset_q    <= '0;
            en_clk_reset_q <= 1'b0;
            en_q           <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            taken_q        <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            prog_addr_q    <= prog_addr_d;
            loc_q          <= loc_d;
            ir_target_q    <= ir_target_d;
            ir_opcode_q    <= ir_opcode_d;
            acc_q          <= acc_d;
            op_q           <= op_d;
            lng_q          <= lng_d;
            addr_q         <= addr_d;
            imm_lo_q       <= imm_lo_d;
            imm_hi_q       <= imm_hi_d;
            clk_reset_q    <= clk_reset_d;
            en_clk_reset_q <= en_clk_reset_d;
            en_q           <= en_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            taken_q        <= taken_d;
            illegal_q      <= illegal_d;
        end
    end

    assign prog_addr    = prog_addr_q;
    assign en           = en_q;
    assign lng          = lng_q;
    assign op           = op_q;
    assign addr         = addr_q;
    assign imm_lo       = imm_lo_q;
    assign imm_hi       = imm_hi_q;
    assign en_clk_reset = en_clk_reset_q;
    assign clk_reset    = clk_reset_q;
    assign loc          = loc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign taken        = taken_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_guard_sequencer.sv
// Directed bench for guard_sequencer with a synchronous-read program memory model
// and per-instruction guard results driven on out_val.
module tb_guard_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  prog_addr;
    logic [23:0] prog_data = '0;
    logic        out_val = 1'b0;
    logic        en, lng, op, en_clk_reset, busy, done, taken, illegal;
    logic [1:0]  addr;
    logic [3:0]  imm_lo;
    logic [7:0]  imm_hi, clk_reset, loc;

    logic [23:0] mem [0:255];
    logic        guard_val [0:15];

    int check_count = 0;
    int pass_count  = 0;

    int ecr_count, ecr_cycle, en_count, en_cycle, done_cycle;
    logic [7:0] ecr_mask;
    logic taken_at_done, illegal_at_done, busy_ok;
    logic snap_lng, snap_op;
    logic [1:0] snap_addr;
    logic [3:0] snap_imm_lo;
    logic [7:0] snap_imm_hi;

    guard_sequencer #(.AW(8), .IW(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .out_val      (out_val),
        .en           (en),
        .lng          (lng),
        .op           (op),
        .addr         (addr),
        .imm_lo       (imm_lo),
        .imm_hi       (imm_hi),
        .en_clk_reset (en_clk_reset),
        .clk_reset    (clk_reset),
        .loc          (loc),
        .busy         (busy),
        .done         (done),
        .taken        (taken),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prog_data <= mem[prog_addr];

    function automatic logic [23:0] enc_guard(input logic c_op, input logic c_lng,
                                              input logic [1:0] c_addr, input logic [7:0] c_hi,
                                              input logic [3:0] c_lo);
        return {2'b00, c_op, c_lng, c_addr, c_hi, c_lo, 6'b0};
    endfunction

    function automatic logic [23:0] enc_take(input logic [7:0] mask, input logic [7:0] target);
        return {2'b01, mask, 6'b0, target};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One pass: start sampled at edge 0, observations taken mid-cycle c (negedge).
    task automatic applyStimulus(input logic poke_start);
        ecr_count = 0; ecr_cycle = -1; ecr_mask = '0;
        en_count = 0; en_cycle = -1; done_cycle = -1;
        taken_at_done = 1'b0; illegal_at_done = 1'b0; busy_ok = 1'b1;
        out_val = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c >= 3 && (c % 3) == 0) out_val = guard_val[(c / 3) - 1];
            if (poke_start && c == 4) start = 1'b1;
            if (poke_start && c == 5) start = 1'b0;
            if (en_clk_reset) begin
                ecr_count++;
                if (ecr_cycle < 0) begin
                    ecr_cycle = c;
                    ecr_mask  = clk_reset;
                end
            end
            if (en) begin
                en_count++;
                en_cycle = c;
            end
            if (c == 3) begin
                snap_lng = lng; snap_op = op; snap_addr = addr;
                snap_imm_lo = imm_lo; snap_imm_hi = imm_hi;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_cycle      = c;
                taken_at_done   = taken;
                illegal_at_done = illegal;
                break;
            end
        end
        if (done_cycle < 0) checkOutput("pass_timeout", 32'd0, 32'd1);
        @(negedge clk);
        out_val = 1'b0;
    endtask

    initial begin
        int en_seen;
        for (int i = 0; i < 256; i++) mem[i] = 24'h800000;
        for (int i = 0; i < 16; i++) guard_val[i] = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_en", en, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_loc", loc, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_prog_addr", prog_addr, 0);
        checkOutput("rst_clk_reset", {en_clk_reset, clk_reset}, 0);
        reset = 1'b0;

        // Guard true
        mem[0] = enc_guard(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        mem[1] = enc_take(8'h01, 8'd5);
        applyStimulus(1'b0);
        checkOutput("gt_ecr_cycle", ecr_cycle, 6);
        checkOutput("gt_ecr_count", ecr_count, 1);
        checkOutput("gt_ecr_mask", ecr_mask, 8'h01);
        checkOutput("gt_done_cycle", done_cycle, 7);
        checkOutput("gt_en_cycle", en_cycle, 7);
        checkOutput("gt_en_count", en_count, 1);
        checkOutput("gt_taken", taken_at_done, 1);
        checkOutput("gt_loc", loc, 5);
        checkOutput("gt_busy_window", busy_ok, 1);
        checkOutput("gt_busy_after", busy, 0);

        // Guard false
        doReset();
        mem[2] = 24'h800000;
        guard_val[0] = 1'b0;
        applyStimulus(1'b0);
        checkOutput("gf_ecr_count", ecr_count, 0);
        checkOutput("gf_done_cycle", done_cycle, 10);
        checkOutput("gf_en_count", en_count, 1);
        checkOutput("gf_taken", taken_at_done, 0);
        checkOutput("gf_loc", loc, 0);
        guard_val[0] = 1'b1;

        // 12-bit guard operands
        doReset();
        mem[0] = enc_guard(1'b0, 1'b1, 2'd1, 8'h12, 4'h3);
        mem[1] = 24'h800000;
        applyStimulus(1'b0);
        checkOutput("g12_lng", snap_lng, 1);
        checkOutput("g12_addr", snap_addr, 1);
        checkOutput("g12_imm_hi", snap_imm_hi, 8'h12);
        checkOutput("g12_imm_lo", snap_imm_lo, 4'h3);
        checkOutput("g12_op", snap_op, 0);
        checkOutput("g12_done_cycle", done_cycle, 7);

        // Two TAKEs, first fails; start poked mid-pass must be ignored
        doReset();
        mem[0] = enc_guard(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        mem[1] = enc_take(8'hFF, 8'd3);
        mem[2] = enc_guard(1'b1, 1'b0, 2'd2, 8'h00, 4'h7);
        mem[3] = enc_take(8'h0A, 8'd9);
        guard_val[0] = 1'b0;
        guard_val[2] = 1'b1;
        applyStimulus(1'b1);
        checkOutput("tt_ecr_count", ecr_count, 1);
        checkOutput("tt_ecr_cycle", ecr_cycle, 12);
        checkOutput("tt_ecr_mask", ecr_mask, 8'h0A);
        checkOutput("tt_done_cycle", done_cycle, 13);
        checkOutput("tt_taken", taken_at_done, 1);
        checkOutput("tt_loc", loc, 9);
        guard_val[0] = 1'b1;

        // Reserved opcode, then illegal must survive the next pass
        doReset();
        mem[0] = 24'hC00000;
        applyStimulus(1'b0);
        checkOutput("rsv_done_cycle", done_cycle, 4);
        checkOutput("rsv_illegal", illegal_at_done, 1);
        checkOutput("rsv_taken", taken_at_done, 0);
        mem[0] = 24'h800000;
        applyStimulus(1'b0);
        checkOutput("rsv2_done_cycle", done_cycle, 4);
        checkOutput("rsv2_illegal", illegal_at_done, 1);

        // Reset mid-pass while the clock-reset pulse is up
        mem[0] = enc_guard(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        mem[1] = enc_take(8'h01, 8'd5);
        out_val = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("mid_ecr_before", en_clk_reset, 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_ecr", en_clk_reset, 0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_loc", loc, 0);
        checkOutput("mid_illegal", illegal, 0);
        checkOutput("mid_clk_reset", clk_reset, 0);
        en_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) reset = 1'b0;
            if (en || done || busy) en_seen++;
        end
        checkOutput("mid_no_en", en_seen, 0);
        checkOutput("mid_loc_after", loc, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/guard_sequencer.md
# guard_sequencer

Program-driven sequencer that sits directly upstream of `clocks_module`. It walks the guard/transition list of the current location in an external program memory and drives the clock-constraint query ports (`lng`, `op`, `addr`, `imm_lo`, `imm_hi`). It ANDs `out_val` results into a guard accumulator and, on the first satisfied transition, issues the clock-reset mask and changes location. Each evaluation pass ends with a single `en` pulse that advances the clocks.

## Interface

Parameters:
- `AW`, 8: program address / location width.
- `IW`, 24: instruction width. Fixed field layout; only 24 is supported.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a pass at `loc`. Sampled only in IDLE.
- `prog_addr` out AW: program memory address (registered).
- `prog_data` in IW: program word. Synchronous read, valid the cycle after `prog_addr`.
- `out_val` in 1: constraint result from `clocks_module`. Combinational, sampled in EXEC.
- `en` out 1: one-cycle clock-advance pulse.
- `lng`, `op` out 1 each: constraint select and operation (`op`=1 is equals, `op`=0 is less-than).
- `addr` out 2, `imm_lo` out 4, `imm_hi` out 8: constraint operands.
- `en_clk_reset` out 1, `clk_reset` out 8: clock-reset pulse and mask.
- `loc` out AW: current location entry address.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle end-of-pass pulse.
- `taken` out 1: a transition fired in the last pass. Valid with `done`, held until the next `start`.
- `illegal` out 1: sticky error flag.

## Operation

Instruction fields:
- Opcode is `prog_data[23:22]`.
- `00` GUARD: `[21]` op, `[20]` lng, `[19:18]` addr, `[17:10]` imm_hi, `[9:6]` imm_lo. Action: `acc <= acc & out_val`.
- `01` TAKE: `[21:14]` reset mask, `[AW-1:0]` target.
  - If `acc`=1: `en_clk_reset`=1 with `clk_reset`=mask for one cycle, `loc <= target`, `taken <= 1`, go to END.
  - If `acc`=0: `acc <= 1`, `pc <= pc+1`.
- `10` END: no transition fired; go to END with `taken`=0.
- `11` reserved: set `illegal`, go to END with `taken`=0.

FSM states: IDLE, FETCH, DECODE, EXEC, END.
- IDLE, `start`=1: `pc <= loc`, `acc <= 1`, `taken <= 0`, go to FETCH.
- FETCH: `prog_addr = pc`, go to DECODE.
- DECODE: register `prog_data` into the instruction register and the constraint ports, go to EXEC.
- EXEC: execute the opcode. GUARD and failed TAKE do `pc <= pc+1` and return to FETCH.
- PC overflow: if `pc` would increment from `2^AW-1`, set `illegal` and go to END.
- END: `en`=1 and `done`=1 for one cycle, `busy`=0 next, return to IDLE.

Rules:
- At most one transition fires per pass; `clk_reset` is asserted at most once per pass.
- Constraint ports outside EXEC hold their last value. Only the EXEC-cycle value is meaningful.
- `en` is low throughout a pass, so clock values are stable while guards are evaluated. The clock reset is latched by `clocks_module` and applied on the END `en` pulse.

## Timing

Reset values (asynchronous):
- State = IDLE.
- `loc`, `pc`, `prog_addr`, all constraint ports, and `clk_reset` = 0.
- `en`, `en_clk_reset`, `busy`, `done`, `taken`, `illegal` = 0.
- `acc` = 1.

Latency:
- Each instruction takes 3 cycles (FETCH, DECODE, EXEC).
- For a `start` sampled at edge 0 and a pass of N instructions: EXEC of instruction i is cycle 3i+3, and END/`done`/`en` is cycle 3N+1.
- `busy` is high from cycle 1 through cycle 3N+1.

Boundary conditions:
- `start` asserted while busy or in END is ignored. Back-to-back passes have a minimum of 1 IDLE cycle between `done` and the next FETCH.
- `reset` mid-pass aborts immediately. Any in-flight `en_clk_reset` or `en` is not emitted, and `loc` returns to 0.
- `illegal` is cleared only by `reset`.

## Structure

- Shared package `rte_seq_pkg`:
  - Opcode constants `OP_GUARD`, `OP_TAKE`, `OP_END`, `OP_RSVD`.
  - Field offsets and widths.
  - FSM state enum.
- Sub-module `seq_decode`: combinational field extraction from `prog_data` into the compare operands, mask, target and opcode. The FSM, `pc`, `acc` and all output registers stay in `guard_sequencer`.

## Test plan

- **Reset:** assert `reset` mid-pass → all outputs 0, `loc`=0, `illegal`=0, state IDLE, with no `en` pulse.
- **Guard true:** prog[0]=GUARD(op=1, lng=0, addr=0, imm_lo=0), prog[1]=TAKE(mask=0x01, target=5), `out_val`=1, `start` at edge 0 → `en_clk_reset`=1 with `clk_reset`=0x01 at cycle 6; `done`=`en`=1 and `taken`=1 at cycle 7; `loc`=5.
- **Guard false:** same program plus prog[2]=END, `out_val`=0 → no `en_clk_reset`, `done` at cycle 10, `taken`=0, `loc`=0.
- **12-bit guard:** GUARD(lng=1, addr=1, imm_hi=0x12, imm_lo=0x3, op=0) → during EXEC `lng`=1, `addr`=1, `imm_hi`=0x12, `imm_lo`=0x3, `op`=0.
- **Reserved opcode:** prog[0]=`11` → `illegal`=1 at cycle 4, `done` at cycle 4, `taken`=0; `illegal` stays 1 across the next pass.
- **Two TAKEs, first fails:** GUARD false, TAKE(0xFF, 3), GUARD true, TAKE(0x0A, 9) → exactly one `en_clk_reset` with mask 0x0A at cycle 12, `loc`=9, `done` at cycle 13.
